// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: imem address generation, PC/word pairing, decode output register
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    input  logic        out_ready,
    output logic [31:0] fetch_count
);

    logic [31:0] req_pc_q, req_pc_d;
    logic        req_valid_q, req_valid_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        accept;
    logic        handshake;
    logic [31:0] next_addr;
    logic        redirect_lsb_unused;

    assign redirect_lsb_unused = ^redirect_pc[1:0];

    always_comb begin
        accept    = req_valid_q && !redirect_valid && (!out_valid_q || out_ready);
        handshake = out_valid_q && out_ready && !redirect_valid;

        // Replaying req_pc_q on a stall keeps the same word on imem_inst next cycle.
        if (rst) begin
            next_addr = RESET_PC;
        end else if (redirect_valid) begin
            next_addr = {redirect_pc[31:2], 2'b00};
        end else if (!req_valid_q) begin
            next_addr = req_pc_q;
        end else if (accept) begin
            next_addr = req_pc_q + 32'd4;
        end else begin
            next_addr = req_pc_q;
        end

        req_pc_d    = next_addr;
        req_valid_d = 1'b1;

        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        if (redirect_valid) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_pc_d    = req_pc_q;
            out_inst_d  = imem_inst;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        fetch_count_d = fetch_count_q + {31'd0, handshake};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_pc_q      <= RESET_PC;
            req_valid_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            out_pc_q      <= 32'd0;
            out_inst_q    <= 32'd0;
            fetch_count_q <= 32'd0;
        end else begin
            req_pc_q      <= req_pc_d;
            req_valid_q   <= req_valid_d;
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_inst_q    <= out_inst_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = next_addr;
    assign out_valid   = out_valid_q;
    assign out_pc      = out_pc_q;
    assign out_inst    = out_inst_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage placed directly upstream of the instruction memory and directly downstream-facing to decode. It generates the fetch address for the synchronous one-cycle-latency instruction memory and pairs each returned word with its PC. It presents the pair to decode through a valid/ready register stage. It also handles branch/jump redirects from execute and back-pressure from decode without losing or duplicating instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- imem_addr  out  32  fetch byte address to instruction memory `addr`. Combinational.
- imem_inst  in  32  instruction memory `inst`. It holds the word addressed by the previous cycle's imem_addr.
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_pc  in  32  redirect target. Bits [1:0] are ignored and treated as 0.
- out_valid  out  1  out_pc/out_inst hold a valid instruction for decode.
- out_pc  out  32  byte address of out_inst.
- out_inst  out  32  fetched instruction.
- out_ready  in  1  decode accepts the output this cycle.
- fetch_count  out  32  number of instructions handed to decode (out_valid && out_ready), wraps at 2^32.

## Operation
- State registers:
  - req_pc_q: address issued last cycle.
  - req_valid_q: imem_inst is meaningful this cycle.
  - Output registers out_valid, out_pc, out_inst.
  - Counter fetch_count.
- accept = req_valid_q && !redirect_valid && (!out_valid || out_ready).
- imem_addr selection, in priority order:
  - rst: RESET_PC.
  - redirect_valid: {redirect_pc[31:2],2'b00}.
  - !req_valid_q: req_pc_q.
  - accept: req_pc_q + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - otherwise: req_pc_q. This replays the address, so imem_inst re-presents the same word while decode stalls.
- Every non-reset cycle: req_pc_q <= imem_addr and req_valid_q <= 1.
- Output stage, in priority order:
  - redirect_valid: out_valid <= 0. The word on imem_inst is discarded. The flush has priority over out_ready; a held instruction is dropped and not counted.
  - accept: out_valid <= 1, out_pc <= req_pc_q, out_inst <= imem_inst.
  - out_ready: out_valid <= 0.
  - otherwise: hold.
- While out_valid && !out_ready (and no redirect), out_pc/out_inst are held stable and out_valid stays high.
- fetch_count increments when out_valid && out_ready && !redirect_valid.
- Reset values:
  - req_pc_q = RESET_PC, req_valid_q = 0.
  - out_valid = 0, out_pc = 0, out_inst = 0.
  - fetch_count = 0.
- Reset dominates redirect_valid and out_ready.
- Reset asserted mid-stream drops the in-flight and held instructions. The instruction memory produces no new word while rst is high; req_valid_q = 0 covers this.

## Timing
- First cycle with rst low (C0): imem_addr = RESET_PC.
- C1: req_valid_q = 1, and the RESET_PC word is accepted.
- C2: out_valid = 1, out_pc = RESET_PC. Reset-to-first-instruction latency is 2 cycles.
- Steady state with out_ready = 1: one instruction per cycle, out_pc increments by 4 each cycle.
- Redirect asserted in cycle T:
  - Cycle T+1: out_valid = 0.
  - Cycle T+2: out_valid = 1 with out_pc = target.
  - Penalty is 2 cycles after the redirect cycle. Only one redirect pulse per target is required.
- Back-to-back redirects in consecutive cycles: the last one wins. No instruction from the earlier target is output.
- Stall release: out_ready rising in cycle S while the replayed word is on imem_inst gives the next sequential instruction at S+1. There is no bubble.

## Test plan
- Reset release, RESET_PC = 0x100, memory holds word i = 0xA000_0000+i at address 4i, out_ready = 1 → out_valid first high 2 cycles after release, then out_pc 0x100, 0x104, 0x108 with out_inst 0xA000_0040, 0xA000_0041, 0xA000_0042 on consecutive cycles.
- Hold out_ready = 0 for 5 cycles while out_pc = 0x104 → out_pc/out_inst stable for all 5 cycles. After release, the sequence resumes at 0x108 with no skip or duplicate, and fetch_count increases by exactly 1 per handshake.
- redirect_valid pulse with redirect_pc = 0x203 while streaming → the next out_valid instruction has out_pc = 0x200 exactly 2 cycles later. No instruction is emitted between the pulse and it.
- redirect coincident with out_valid && !out_ready → the held instruction is dropped (fetch_count unchanged), and the target is emitted 2 cycles later.
- Redirect to 0xFFFF_FFFC with out_ready = 1 → out_pc 0xFFFF_FFFC then 0x0000_0000.
- rst asserted for 1 cycle mid-stream with redirect_valid = 1 → out_valid = 0 and fetch_count = 0 the next cycle, and the stream restarts at RESET_PC with 2-cycle latency.
